// File: rtl/scan_mux_reg.sv
// Registered CHANNELS:1 word multiplexer with valid/ready output.
// DIRECT forwards a requested channel; SCAN walks the enabled channels round-robin.
module scan_mux_reg #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned WIDTH    = 8,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_mode,
    input  logic [SEL_W-1:0]          i_sel,
    input  logic                      i_sel_valid,
    input  logic [CHANNELS*WIDTH-1:0] i_din,
    input  logic [CHANNELS-1:0]       i_ch_en,
    output logic [WIDTH-1:0]          o_dout,
    output logic [SEL_W-1:0]          o_dout_ch,
    output logic                      o_dout_valid,
    input  logic                      i_dout_ready,
    output logic                      o_sel_err,
    output logic                      o_busy
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDirect = 2'd1,
        StScan   = 2'd2,
        StDrain  = 2'd3
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_dout;
    logic [SEL_W-1:0] r_dout_ch;
    logic [SEL_W-1:0] r_ptr;
    logic             r_valid;
    logic             r_sel_err;

    logic [WIDTH-1:0] w_words [CHANNELS];
    logic             w_free;
    logic             w_sel_ok;
    logic             w_dir_cap;
    logic             w_scan_cap;
    logic             w_cap;
    logic [SEL_W-1:0] w_cap_ch;
    logic             w_scan_hit;
    logic [SEL_W-1:0] w_scan_tgt;
    logic [SEL_W-1:0] w_ptr_next;
    int unsigned      w_idx;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_words
        assign w_words[k] = i_din[k*WIDTH +: WIDTH];
    end

    assign w_free   = !r_valid || i_dout_ready;
    assign w_sel_ok = 32'(i_sel) < CHANNELS;

    // First enabled channel at or after the pointer, wrapping within 0..CHANNELS-1.
    always_comb begin
        w_scan_hit = 1'b0;
        w_scan_tgt = '0;
        w_idx      = 0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_idx = 32'(r_ptr) + i;
            if (w_idx >= CHANNELS) begin
                w_idx = w_idx - CHANNELS;
            end
            if (!w_scan_hit && i_ch_en[w_idx[SEL_W-1:0]]) begin
                w_scan_hit = 1'b1;
                w_scan_tgt = w_idx[SEL_W-1:0];
            end
        end
    end

    assign w_ptr_next = (32'(w_scan_tgt) == CHANNELS - 1) ? '0
                      : SEL_W'(32'(w_scan_tgt) + 32'd1);

    assign w_dir_cap  = (r_state == StDirect) && i_sel_valid && w_sel_ok && w_free;
    assign w_scan_cap = (r_state == StScan) && w_scan_hit && w_free;
    assign w_cap      = w_dir_cap || w_scan_cap;
    assign w_cap_ch   = w_scan_cap ? w_scan_tgt : i_sel;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_dout    <= '0;
            r_dout_ch <= '0;
            r_ptr     <= '0;
            r_valid   <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            // Bad index is flagged regardless of backpressure.
            r_sel_err <= (r_state == StDirect) && i_sel_valid && !w_sel_ok;

            if (w_cap) begin
                r_dout    <= w_words[w_cap_ch];
                r_dout_ch <= w_cap_ch;
                r_valid   <= 1'b1;
            end else if (i_dout_ready) begin
                r_valid <= 1'b0;
            end

            if (w_scan_cap) begin
                r_ptr <= w_ptr_next;
            end

            case (r_state)
                StIdle: begin
                    r_state <= i_mode ? StScan : StDirect;
                end
                StDirect: begin
                    if (i_mode) begin
                        r_state <= r_valid ? StDrain : StScan;
                    end
                end
                StScan: begin
                    if (!i_mode) begin
                        r_state <= r_valid ? StDrain : StDirect;
                    end
                end
                StDrain: begin
                    // A held word must finish its handshake before the new mode captures.
                    if (w_free) begin
                        r_state <= i_mode ? StScan : StDirect;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_ch    = r_dout_ch;
    assign o_dout_valid = r_valid;
    assign o_sel_err    = r_sel_err;
    assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_scan_mux_reg.sv
// Bench for scan_mux_reg: 8- and 5-channel instances share stimulus and are
// checked each cycle against a spec-level model, plus directed literal checks.
module tb_scan_mux_reg;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [2:0]  sel;
    logic        sel_valid;
    logic [63:0] din;
    logic [7:0]  ch_en;
    logic        ready;

    logic [7:0]  o8_dout;
    logic [2:0]  o8_ch;
    logic        o8_valid;
    logic        o8_err;
    logic        o8_busy;
    logic [7:0]  o5_dout;
    logic [2:0]  o5_ch;
    logic        o5_valid;
    logic        o5_err;
    logic        o5_busy;

    int total = 0;
    int bad   = 0;

    scan_mux_reg #(.CHANNELS(8), .WIDTH(8)) u8 (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel), .i_sel_valid(sel_valid),
        .i_din(din), .i_ch_en(ch_en), .o_dout(o8_dout), .o_dout_ch(o8_ch),
        .o_dout_valid(o8_valid), .i_dout_ready(ready), .o_sel_err(o8_err), .o_busy(o8_busy)
    );

    scan_mux_reg #(.CHANNELS(5), .WIDTH(8)) u5 (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel), .i_sel_valid(sel_valid),
        .i_din(din[39:0]), .i_ch_en(ch_en[4:0]), .o_dout(o5_dout), .o_dout_ch(o5_ch),
        .o_dout_valid(o5_valid), .i_dout_ready(ready), .o_sel_err(o5_err), .o_busy(o5_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: one record per instance.
    localparam int M_IDLE = 0, M_DIRECT = 1, M_SCAN = 2, M_DRAIN = 3;
    typedef struct {
        int st;
        int ptr;
        bit valid;
        int dout;
        int ch;
        bit err;
    } mdl_t;

    mdl_t m [2];
    int   nch [2] = '{8, 5};

    function automatic mdl_t mdl_step(input mdl_t s, input int n);
        mdl_t r;
        bit   free;
        int   tgt;
        r    = s;
        free = !s.valid || ready;
        tgt  = -1;
        r.err = 1'b0;
        case (s.st)
            M_IDLE: r.st = mode ? M_SCAN : M_DIRECT;
            M_DIRECT: begin
                if (sel_valid && int'(sel) >= n) r.err = 1'b1;
                else if (sel_valid && free) tgt = int'(sel);
                if (mode) r.st = s.valid ? M_DRAIN : M_SCAN;
            end
            M_SCAN: begin
                if (free) begin
                    for (int i = 0; i < n; i++) begin
                        if (tgt < 0 && ch_en[(s.ptr + i) % n]) tgt = (s.ptr + i) % n;
                    end
                    if (tgt >= 0) r.ptr = (tgt + 1) % n;
                end
                if (!mode) r.st = s.valid ? M_DRAIN : M_DIRECT;
            end
            default: if (free) r.st = mode ? M_SCAN : M_DIRECT;
        endcase
        if (tgt >= 0) begin
            r.dout  = int'(din[tgt*8 +: 8]);
            r.ch    = tgt;
            r.valid = 1'b1;
        end else if (ready) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) m[d] = '{M_IDLE, 0, 1'b0, 0, 0, 1'b0};
            else     m[d] = mdl_step(m[d], nch[d]);
        end
    end

    always @(negedge clk) begin
        chk("u8.valid", 32'(o8_valid), 32'(m[0].valid));
        chk("u8.dout",  32'(o8_dout),  m[0].dout);
        chk("u8.ch",    32'(o8_ch),    m[0].ch);
        chk("u8.err",   32'(o8_err),   32'(m[0].err));
        chk("u8.busy",  32'(o8_busy),  32'(m[0].st != M_IDLE));
        chk("u5.valid", 32'(o5_valid), 32'(m[1].valid));
        chk("u5.dout",  32'(o5_dout),  m[1].dout);
        chk("u5.ch",    32'(o5_ch),    m[1].ch);
        chk("u5.err",   32'(o5_err),   32'(m[1].err));
        chk("u5.busy",  32'(o5_busy),  32'(m[1].st != M_IDLE));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int scan_seq [6] = '{0, 2, 5, 7, 0, 2};
        int wrap_seq [3] = '{4, 0, 4};

        rst = 1'b1; mode = 1'b0; sel = '0; sel_valid = 1'b0; ready = 1'b0; ch_en = '0;
        din = 64'h7766_A544_3322_1100;
        tick(); tick();
        chk("rst.busy", 32'(o8_busy), 0);
        chk("rst.valid", 32'(o8_valid), 0);
        rst = 1'b0;
        tick();
        chk("post_rst.busy", 32'(o8_busy), 1);

        // DIRECT single request
        sel = 3'd5; sel_valid = 1'b1; ready = 1'b1;
        tick();
        chk("dir.dout", 32'(o8_dout), 32'hA5);
        chk("dir.ch", 32'(o8_ch), 5);
        chk("dir.valid", 32'(o8_valid), 1);
        chk("dir.u5_err", 32'(o5_err), 1);
        sel_valid = 1'b0;
        tick();
        chk("dir.valid_fall", 32'(o8_valid), 0);

        // Backpressure drops a second request
        sel = 3'd5; sel_valid = 1'b1; ready = 1'b0;
        tick();
        chk("bp.first", 32'(o8_ch), 5);
        sel = 3'd2;
        tick();
        chk("bp.hold_dout", 32'(o8_dout), 32'hA5);
        chk("bp.hold_ch", 32'(o8_ch), 5);
        chk("bp.hold_valid", 32'(o8_valid), 1);
        sel_valid = 1'b0; ready = 1'b1;
        tick();
        chk("bp.dropped_valid", 32'(o8_valid), 0);
        chk("bp.dropped_ch", 32'(o8_ch), 5);

        // Mode switch with held word -> DRAIN, scan starts after handshake
        sel = 3'd3; sel_valid = 1'b1; ready = 1'b0;
        tick();
        chk("sw.held_dout", 32'(o8_dout), 32'h33);
        sel_valid = 1'b0; mode = 1'b1; ch_en = 8'hA5;
        tick();
        chk("sw.drain_busy", 32'(o8_busy), 1);
        chk("sw.drain_ch", 32'(o8_ch), 3);
        tick();
        chk("sw.drain_hold", 32'(o8_ch), 3);
        chk("sw.drain_valid", 32'(o8_valid), 1);
        ready = 1'b1;
        tick();
        chk("sw.handshake", 32'(o8_valid), 0);

        // SCAN round-robin from ptr 0
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("scan.ch", 32'(o8_ch), scan_seq[i]);
            chk("scan.valid", 32'(o8_valid), 1);
        end

        // Empty mask: drains, pointer kept
        ch_en = 8'h00;
        tick();
        chk("scan.empty_valid", 32'(o8_valid), 0);
        tick();
        ch_en = 8'hFF;
        tick();
        chk("scan.ptr_kept", 32'(o8_ch), 3);
        ch_en = 8'h01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("scan.only0", 32'(o8_ch), 0);
            chk("scan.only0_valid", 32'(o8_valid), 1);
        end
        ch_en = 8'h11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("scan.wrap8", 32'(o8_ch), wrap_seq[i]);
            chk("scan.wrap5", 32'(o5_ch), wrap_seq[i]);
        end
        ready = 1'b0;
        tick();
        chk("scan.bp_hold", 32'(o8_ch), 4);
        chk("scan.bp_valid", 32'(o8_valid), 1);

        // Back to DIRECT, out-of-range select on the 5-channel instance
        ready = 1'b1; mode = 1'b0;
        tick(); tick(); tick();
        sel = 3'd6; sel_valid = 1'b1;
        tick();
        chk("err.pulse", 32'(o5_err), 1);
        chk("err.no_cap", 32'(o5_valid), 0);
        chk("err.u8_cap", 32'(o8_dout), 32'h66);
        sel_valid = 1'b0;
        tick();
        chk("err.pulse_end", 32'(o5_err), 0);
        sel = 3'd1; sel_valid = 1'b1; ready = 1'b0;
        tick();
        sel = 3'd6;
        tick();
        chk("err.full_pulse", 32'(o5_err), 1);
        chk("err.full_hold", 32'(o5_ch), 1);
        sel_valid = 1'b0;
        tick();

        // Asynchronous reset mid-transfer
        chk("arst.pre_valid", 32'(o8_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst.valid", 32'(o8_valid), 0);
        chk("arst.dout", 32'(o8_dout), 0);
        chk("arst.ch", 32'(o8_ch), 0);
        chk("arst.busy", 32'(o8_busy), 0);
        chk("arst.err", 32'(o8_err), 0);
        tick();
        rst = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
